// File: rtl/dsp_ex_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module   : dsp_ex_ctrl_v2
// Brief    : Execution-phase address sequencer for the DSP PE array. Walks
//            depth/K/HW loops over a latched tile description, issues
//            act/wgt/out buffer addresses through a 2-stage pipeline, emits
//            partial-sum select windows and a start/busy/done handshake.
// Config   : DSP_EX_CTRL_STALL_EN - when defined, ex_stall freezes issue;
//            when undefined, ex_stall is ignored and issue is unconditional.
// Revision : 2.0 - parametrised successor of the fixed-width ex-controller
// ============================================================================
module dsp_ex_ctrl_v2 #(
  parameter int ROWS    = 16,
  parameter int DIM_W   = 8,
  parameter int DEPTH_W = 16,
  parameter int ACT_AW  = 12,
  parameter int WGT_AW  = 12,
  parameter int OUT_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIM_W-1:0]   cfg_K,
  input  logic [DIM_W-1:0]   cfg_HW,
  input  logic [DEPTH_W-1:0] cfg_CIJ,
  input  logic               cfg_loop_order,
  input  logic               tile_start,
  input  logic               ex_stall,
  output logic               tile_busy,
  output logic               tile_done,
  output logic [ACT_AW-1:0]  act_addr,
  output logic [WGT_AW-1:0]  wgt_addr,
  output logic [OUT_AW-1:0]  out_addr,
  output logic               addr_valid,
  output logic               psum_sel
);

  // Wide enough that every product and sum below is exact before truncation.
  localparam int         c_PW       = DIM_W + DEPTH_W + OUT_AW;
  localparam logic [5:0] c_WIN_LOAD = 6'(ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [DIM_W-1:0]   r_k_cfg;
  logic [DIM_W-1:0]   r_hw_cfg;
  logic [DEPTH_W-1:0] r_cij;
  logic               r_order;
  logic [OUT_AW-1:0]  r_hwcij;
  logic [DIM_W-1:0]   r_k;
  logic [DIM_W-1:0]   r_hw;
  logic [DEPTH_W-1:0] r_d;

  logic               r_s1_valid;
  logic [ACT_AW-1:0]  r_p_act;
  logic [WGT_AW-1:0]  r_p_wgt;
  logic [OUT_AW-1:0]  r_p_out_k;
  logic [OUT_AW-1:0]  r_p_out_hw;
  logic [DEPTH_W-1:0] r_s1_d;

  logic               r_valid;
  logic [ACT_AW-1:0]  r_act;
  logic [WGT_AW-1:0]  r_wgt;
  logic [OUT_AW-1:0]  r_out;
  logic [5:0]         r_win;

  logic w_stall;
  logic w_issue;
  logic w_d_full;
  logic w_k_full;
  logic w_hw_full;
  logic w_k_adv;
  logic w_hw_adv;
  logic w_last;
  logic w_zero;

`ifdef DSP_EX_CTRL_STALL_EN
  assign w_stall = ex_stall;
`else
  logic w_unused_stall;
  assign w_unused_stall = ex_stall;
  assign w_stall        = 1'b0;
`endif

  assign w_issue   = (r_state == S_RUN) && !w_stall;
  assign w_d_full  = (r_d  == r_cij    - DEPTH_W'(1));
  assign w_k_full  = (r_k  == r_k_cfg  - DIM_W'(1));
  assign w_hw_full = (r_hw == r_hw_cfg - DIM_W'(1));
  // The middle loop advances on every depth wrap; the outer loop also needs
  // the middle loop full. Loop order only swaps which of K/HW is which.
  assign w_k_adv   = w_d_full && (r_order ? w_hw_full : 1'b1);
  assign w_hw_adv  = w_d_full && (r_order ? 1'b1 : w_k_full);
  assign w_last    = w_d_full && w_k_full && w_hw_full;
  assign w_zero    = (cfg_K == '0) || (cfg_HW == '0) || (cfg_CIJ == '0);

  // Control FSM: tile latch, loop counters and the busy/done handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_k_cfg  <= '0;
      r_hw_cfg <= '0;
      r_cij    <= '0;
      r_order  <= 1'b0;
      r_hwcij  <= '0;
      r_k      <= '0;
      r_hw     <= '0;
      r_d      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tile_start) begin
            r_k_cfg  <= cfg_K;
            r_hw_cfg <= cfg_HW;
            r_cij    <= cfg_CIJ;
            r_order  <= cfg_loop_order;
            r_hwcij  <= OUT_AW'(c_PW'(cfg_HW) * c_PW'(cfg_CIJ));
            r_k      <= '0;
            r_hw     <= '0;
            r_d      <= '0;
            r_busy   <= 1'b1;
            r_state  <= w_zero ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_d <= w_d_full ? '0 : r_d + DEPTH_W'(1);
            if (w_k_adv)  r_k  <= w_k_full  ? '0 : r_k  + DIM_W'(1);
            if (w_hw_adv) r_hw <= w_hw_full ? '0 : r_hw + DIM_W'(1);
            if (w_last)   r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Window counter at 1 closes on this edge, so done lines up with
          // the first cycle after the last psum_sel beat.
          if (!r_s1_valid && (r_win <= 6'd1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: products and depth index; a stalled cycle becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p_act    <= '0;
      r_p_wgt    <= '0;
      r_p_out_k  <= '0;
      r_p_out_hw <= '0;
      r_s1_d     <= '0;
    end else begin
      r_s1_valid <= w_issue;
      if (w_issue) begin
        r_p_act    <= ACT_AW'(c_PW'(r_hw) * c_PW'(r_cij));
        r_p_wgt    <= WGT_AW'(c_PW'(r_k)  * c_PW'(r_cij));
        r_p_out_k  <= OUT_AW'(c_PW'(r_k)  * c_PW'(r_hwcij));
        r_p_out_hw <= OUT_AW'(c_PW'(r_hw) * c_PW'(r_cij));
        r_s1_d     <= r_d;
      end
    end
  end

  // Stage 2: final address sums; addresses hold while no beat is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_act   <= '0;
      r_wgt   <= '0;
      r_out   <= '0;
    end else begin
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_act <= ACT_AW'(c_PW'(r_p_act) + c_PW'(r_s1_d));
        r_wgt <= WGT_AW'(c_PW'(r_p_wgt) + c_PW'(r_s1_d));
        r_out <= OUT_AW'(c_PW'(r_p_out_k) + c_PW'(r_p_out_hw) + c_PW'(r_s1_d));
      end
    end
  end

  // Partial-sum window: (re)loads on every depth-wrap issue, free-runs down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (w_issue && w_d_full) begin
      r_win <= c_WIN_LOAD;
    end else if (r_win != 6'd0) begin
      r_win <= r_win - 6'd1;
    end
  end

  assign tile_busy  = r_busy;
  assign tile_done  = r_done;
  assign act_addr   = r_act;
  assign wgt_addr   = r_wgt;
  assign out_addr   = r_out;
  assign addr_valid = r_valid;
  assign psum_sel   = (r_win != 6'd0);

endmodule
`default_nettype wire
